// File: rtl/pipe_sub16_pkg.sv
// Shared width and carry-select segment constants for the pipelined 16-bit subtractor.
package pipe_sub16_pkg;

    localparam int W        = 16;
    localparam int SEG1_LSB = 4;
    localparam int SEG2_LSB = 9;

    localparam int LO_W  = SEG1_LSB;
    localparam int MID_W = SEG2_LSB - SEG1_LSB;
    localparam int HI_W  = W - SEG2_LSB;

    // Both speculative results of an upper segment, carried from S1 to S2.
    typedef struct packed {
        logic [MID_W-1:0] sum0;
        logic [MID_W-1:0] sum1;
        logic             c0;
        logic             c1;
    } mid_spec_t;

    typedef struct packed {
        logic [HI_W-1:0] sum0;
        logic [HI_W-1:0] sum1;
        logic            c0;
        logic            c1;
    } hi_spec_t;

endpackage

// File: rtl/csel_sub_seg.sv
// One carry-select segment of a - b, computed as a + ~b for both carry-in values.
module csel_sub_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    output logic [SEG_W-1:0] sum0_o,
    output logic             c0_o,
    output logic [SEG_W-1:0] sum1_o,
    output logic             c1_o
);

    logic [SEG_W:0] a_ext;
    logic [SEG_W:0] bn_ext;

    assign a_ext  = {1'b0, a_i};
    assign bn_ext = {1'b0, ~b_i};

    assign {c0_o, sum0_o} = a_ext + bn_ext;
    assign {c1_o, sum1_o} = a_ext + bn_ext + (SEG_W + 1)'(1);

endmodule

// File: rtl/pipe_sub16.sv
// Three-stage pipelined 16-bit subtractor with borrow, carry-select datapath and valid/ready flow control.
module pipe_sub16
    import pipe_sub16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         bo
);

    logic stall;

    logic [W-1:0] a0_q, b0_q;
    logic         bi0_q, v0_q;

    logic [LO_W-1:0] lo_sum0, lo_sum1, lo_sum_d, lo_sum_q;
    logic            lo_c0, lo_c1, lo_c_d, lo_c_q;
    mid_spec_t       mid_d, mid_q;
    hi_spec_t        hi_d, hi_q;
    logic            v1_q;

    logic [MID_W-1:0] mid_sum;
    logic             mid_c;
    logic [HI_W-1:0]  hi_sum;
    logic             hi_c;
    logic [W-1:0]     out_d, out_q;
    logic             bo_d, bo_q, v2_q;

    assign stall     = v2_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v2_q;
    assign out       = out_q;
    assign bo        = bo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q  <= 1'b0;
            a0_q  <= '0;
            b0_q  <= '0;
            bi0_q <= 1'b0;
        end else if (!stall) begin
            v0_q  <= in_valid;
            a0_q  <= inA;
            b0_q  <= inB;
            bi0_q <= bi;
        end
    end

    csel_sub_seg #(.SEG_W(LO_W)) u_lo (
        .a_i    (a0_q[SEG1_LSB-1:0]),
        .b_i    (b0_q[SEG1_LSB-1:0]),
        .sum0_o (lo_sum0),
        .c0_o   (lo_c0),
        .sum1_o (lo_sum1),
        .c1_o   (lo_c1)
    );

    csel_sub_seg #(.SEG_W(MID_W)) u_mid (
        .a_i    (a0_q[SEG2_LSB-1:SEG1_LSB]),
        .b_i    (b0_q[SEG2_LSB-1:SEG1_LSB]),
        .sum0_o (mid_d.sum0),
        .c0_o   (mid_d.c0),
        .sum1_o (mid_d.sum1),
        .c1_o   (mid_d.c1)
    );

    csel_sub_seg #(.SEG_W(HI_W)) u_hi (
        .a_i    (a0_q[W-1:SEG2_LSB]),
        .b_i    (b0_q[W-1:SEG2_LSB]),
        .sum0_o (hi_d.sum0),
        .c0_o   (hi_d.c0),
        .sum1_o (hi_d.sum1),
        .c1_o   (hi_d.c1)
    );

    // Carry-in to the low segment is ~bi, so a borrow-in selects the cin=0 result.
    assign lo_sum_d = bi0_q ? lo_sum0 : lo_sum1;
    assign lo_c_d   = bi0_q ? lo_c0   : lo_c1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            lo_sum_q <= '0;
            lo_c_q   <= 1'b0;
            mid_q    <= '0;
            hi_q     <= '0;
        end else if (!stall) begin
            v1_q     <= v0_q;
            lo_sum_q <= lo_sum_d;
            lo_c_q   <= lo_c_d;
            mid_q    <= mid_d;
            hi_q     <= hi_d;
        end
    end

    assign mid_sum = lo_c_q ? mid_q.sum1 : mid_q.sum0;
    assign mid_c   = lo_c_q ? mid_q.c1   : mid_q.c0;
    assign hi_sum  = mid_c  ? hi_q.sum1  : hi_q.sum0;
    assign hi_c    = mid_c  ? hi_q.c1    : hi_q.c0;
    assign out_d   = {hi_sum, mid_sum, lo_sum_q};
    assign bo_d    = ~hi_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            out_q <= '0;
            bo_q  <= 1'b0;
        end else if (!stall) begin
            v2_q  <= v1_q;
            out_q <= out_d;
            bo_q  <= bo_d;
        end
    end

endmodule

// File: tb/tb_pipe_sub16.sv
// Directed and random checks of pipe_sub16: latency, borrow boundaries, back-pressure, throughput, reset.
module tb_pipe_sub16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] inA = '0;
    logic [15:0] inB = '0;
    logic        bi = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        bo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nres     = 0;
    int tp_mark  = -1;
    int tp_first = 0;
    int last_pop = 0;

    logic [16:0] sb[$];

    pipe_sub16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .bo        (bo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, score the transfers that the next rising edge performs.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic ordy, input logic [16:0] exp, output logic acc, output logic rdy);
        in_valid  = v;
        inA       = a;
        inB       = b;
        bi        = bin;
        out_ready = ordy;
        #1;
        rdy = in_ready;
        acc = v && in_ready;
        if (acc) sb.push_back(exp);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("res_unexpected", 32'(out_valid), 32'd0);
            end else begin
                if (nres == tp_mark) tp_first = cyc;
                check("res", 32'({bo, out}), 32'(sb.pop_front()));
            end
            nres++;
            last_pop = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        logic acc, rdy;
        step(1'b0, 16'h0, 16'h0, 1'b0, ordy, 17'h0, acc, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
        idle(1'b1);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic lat_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic bin, input logic [16:0] exp);
        logic acc, rdy;
        int lat;
        step(1'b1, a, b, bin, 1'b1, exp, acc, rdy);
        check({tag, "_acc"}, 32'(acc), 32'd1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            idle(1'b1);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_val"}, 32'({bo, out}), 32'(exp));
        drain();
    endtask

    logic [15:0] bp_a   [6] = '{16'h0100, 16'h0F0F, 16'h0003, 16'hABCD, 16'h0400, 16'h0000};
    logic [15:0] bp_b   [6] = '{16'h0001, 16'h0F0F, 16'h0004, 16'h1111, 16'h0200, 16'h0000};
    logic [16:0] bp_exp [6] = '{17'h000FF, 17'h00000, 17'h1FFFF, 17'h09ABC, 17'h00200, 17'h00000};

    logic [15:0] dv_a   [6] = '{16'h0000, 16'h1000, 16'h0200, 16'hFFFF, 16'h8000, 16'h0010};
    logic [15:0] dv_b   [6] = '{16'h0001, 16'h0FFF, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h0010};
    logic        dv_bi  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] dv_exp [6] = '{17'h1FFFF, 17'h00000, 17'h001FF, 17'h1FFFF, 17'h00001, 17'h1FFFF};

    initial begin
        logic acc, rdy;
        logic [16:0] snap, mdl;
        logic [15:0] ra, rb;
        logic rbi;
        int idx, held, n0, nacc;
        bit hold;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out",       32'({bo, out}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // out_ready low with an empty pipe is not a stall
        out_ready = 1'b0;
        #1;
        check("idle_nostall", 32'(in_ready), 32'd1);
        @(negedge clk);

        lat_check("basic", 16'h0005, 16'h0003, 1'b0, 17'h00002);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, dv_a[i], dv_b[i], dv_bi[i], 1'b1, dv_exp[i], acc, rdy);
            check("dir_acc", 32'(acc), 32'd1);
        end
        drain();

        // back-pressure: hold the first result for 4 cycles, then release
        idx = 0;
        held = 0;
        n0 = nres;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() > 0); c++) begin
            hold = out_valid && held < 4;
            if (hold) begin
                held++;
                snap = {bo, out};
            end
            step(idx < 5, bp_a[idx], bp_b[idx], 1'b0, !hold, bp_exp[idx], acc, rdy);
            if (acc) idx++;
            if (hold) begin
                check("bp_in_ready", 32'(rdy), 32'd0);
                check("bp_stable",   32'({bo, out}), 32'(snap));
                check("bp_valid",    32'(out_valid), 32'd1);
            end
        end
        check("bp_held",  32'(held), 32'd4);
        check("bp_count", 32'(nres - n0), 32'd5);
        drain();

        // throughput: 100 back-to-back random operands
        n0 = nres;
        tp_mark = nres;
        nacc = 0;
        for (int i = 0; i < 100; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            mdl = {1'b0, ra} - {1'b0, rb} - 17'(rbi);
            step(1'b1, ra, rb, rbi, 1'b1, mdl, acc, rdy);
            if (acc) nacc++;
        end
        drain();
        check("tp_accepted", 32'(nacc), 32'd100);
        check("tp_count",    32'(nres - n0), 32'd100);
        check("tp_span",     32'(last_pop - tp_first), 32'd99);
        tp_mark = -1;

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) step(1'b1, dv_a[i], dv_b[i], dv_bi[i], 1'b0, dv_exp[i], acc, rdy);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out",   32'({bo, out}), 32'd0);
        check("rst_mid_rdy",   32'(in_ready), 32'd1);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n0 = nres;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end
        check("rst_no_results", 32'(nres - n0), 32'd0);
        lat_check("post_rst", 16'h0200, 16'h0001, 1'b0, 17'h001FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_sub16.md
PIPE_SUB16 -- requirements
Module: pipe_sub16

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: in_valid  input  1  operand set on inA/inB/bi is presented.
REQ-004 SHALL provide port: in_ready  output  1  block accepts operands this cycle.
REQ-005 SHALL provide port: inA  input  16  minuend, unsigned.
REQ-006 SHALL provide port: inB  input  16  subtrahend, unsigned.
REQ-007 SHALL provide port: bi  input  1  borrow in.
REQ-008 SHALL provide port: out_valid  output  1  out/bo hold a valid result.
REQ-009 SHALL provide port: out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL provide port: out  output  16  difference.
REQ-011 SHALL provide port: bo  output  1  borrow out.
REQ-012 SHALL have one clock domain; reset is asynchronous and active-high.

Function
REQ-013 SHALL compute out = (inA - inB - bi) mod 2^16, bo = 1 iff inA < inB + bi.
REQ-014 SHALL implement subtraction as inA + ~inB + ~bi, where carry-out c16 gives bo = ~c16.
REQ-015 SHALL split the datapath into carry-select segments [3:0] ripple, [8:4] and [15:9], each computed twice (carry-in 0 and 1), selected by the carry from the segment below.
REQ-016 SHALL have three register stages: S0 input capture; S1 holds low-segment result, low carry and both speculative results for the upper segments; S2 holds the selected out/bo.
REQ-017 SHALL have a latency of exactly 3 rising edges from an accepting edge (in_valid & in_ready) to out_valid = 1 with that result, when no stall occurs.
REQ-018 SHALL define stall = out_valid & ~out_ready, and set in_ready = ~stall.
REQ-019 SHALL hold all stage registers and valid bits unchanged while stall = 1, so out/bo stay stable.
REQ-020 SHALL advance every stage and its valid bit by one position on each edge where stall = 0.
REQ-021 SHALL load a valid bit of 0 into S0 on a non-stalled edge with in_valid = 0, leaving a bubble; bubbles are not collapsed.
REQ-022 SHALL sustain one result per cycle when in_valid = 1 and out_ready = 1 continuously.
REQ-023 SHALL ignore inA/inB/bi while in_valid = 0 or in_ready = 0; no operand is lost or duplicated.
REQ-024 SHALL treat out_ready = 0 with out_valid = 0 as no stall.
REQ-025 SHALL leave data registers free to update when their valid bit is 0; only valid-bit behaviour is checked.

Reset
REQ-026 SHALL, on rst = 1, immediately clear all stage valid bits, out_valid, out and bo to 0, independent of clk.
REQ-027 SHALL hold in_ready = 1 during and after reset, since out_valid = 0.
REQ-028 SHALL discard all in-flight operations when reset is asserted mid-operation; no stale result appears after release.
REQ-029 SHALL allow the first accept on the first rising edge with rst = 0.

Structure
REQ-030 SHALL place a shared package pipe_sub16_pkg holding the width constant (16) and the segment boundary constants (4, 9).
REQ-031 SHALL use one sub-module, csel_sub_seg, parameterised by segment width, that returns the sum and carry-out for carry-in 0 and 1.
REQ-032 SHALL instantiate csel_sub_seg once per upper segment; the low segment reuses it with a single carry-in.

Verification
REQ-033 SHALL cover basic subtraction: inA=0x0005, inB=0x0003, bi=0 -> out=0x0002, bo=0, 3 cycles later.
REQ-034 SHALL cover wrap-around: inA=0x0000, inB=0x0001, bi=0 -> out=0xFFFF, bo=1; and inA=0x1000, inB=0x0FFF, bi=1 -> out=0x0000, bo=0.
REQ-035 SHALL cover a cross-segment borrow: inA=0x0200, inB=0x0001, bi=0 -> out=0x01FF, bo=0, exercising selection in both upper segments.
REQ-036 SHALL cover back-pressure: stream 5 operands with out_ready=0 after the first result -> in_ready=0, out stable, and all 5 results delivered in order once out_ready=1.
REQ-037 SHALL cover throughput: 100 random back-to-back operands with out_ready=1 -> 100 results on 100 consecutive cycles, all matching the reference model.
REQ-038 SHALL cover reset mid-operation: assert rst with 3 operations in flight -> out_valid=0 at once, and no result emerges after release until new inputs arrive.
